// File: rtl/fmul_arbiter_pkg.sv
// Shared definitions for the two-requester fmul arbiter and its response FIFOs.
package fmul_arbiter_pkg;

   localparam int unsigned LATENCY_DEF   = 2;
   localparam int unsigned RSP_DEPTH_DEF = 4;
   localparam int unsigned NUM_REQ       = 2;
   localparam int unsigned REQ_ID_W      = 1;

   typedef logic [REQ_ID_W-1:0] req_id_t;

   // One slot of the in-flight tracking pipeline.
   typedef struct packed {
      logic    valid;
      req_id_t owner;
   } stage_t;

   // Width needed to hold an occupancy count of 0..depth.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fmul_rsp_fifo.sv
// In-order response buffer for one requester; exposes its occupancy for budgeting.
module fmul_rsp_fifo
   import fmul_arbiter_pkg::*;
#(
   parameter int unsigned DEPTH = RSP_DEPTH_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [31:0]                  push_data,
   input  logic                         pop,
   output logic                         valid,
   output logic [31:0]                  head,
   output logic [cnt_width(DEPTH)-1:0]  count
);

   localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CntW = cnt_width(DEPTH);
   localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

   logic [31:0]     mem_q [DEPTH];
   logic [PtrW-1:0] wr_ptr_q;
   logic [PtrW-1:0] rd_ptr_q;
   logic [CntW-1:0] count_q;
   logic            do_pop;

   assign valid  = (count_q != '0);
   assign head   = mem_q[rd_ptr_q];
   assign count  = count_q;
   // A pop on an empty FIFO is ignored rather than corrupting the pointers.
   assign do_pop = pop && valid;

   // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrW'(1);
         end
         if (push && !do_pop) begin
            count_q <= count_q + CntW'(1);
         end else if (!push && do_pop) begin
            count_q <= count_q - CntW'(1);
         end
      end
   end

   // Storage needs no reset: entries are only visible once counted.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/fmul_arbiter.sv
// Round-robin arbiter sharing one pipelined fmul between two requesters, with
// per-requester response FIFOs and credit-style issue budgeting.
module fmul_arbiter
   import fmul_arbiter_pkg::*;
#(
   parameter int unsigned LATENCY   = LATENCY_DEF,
   parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_x1,
   input  logic [31:0] req0_x2,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_x1,
   input  logic [31:0] req1_x2,
   output logic        rsp0_valid,
   input  logic        rsp0_ready,
   output logic [31:0] rsp0_y,
   output logic        rsp1_valid,
   input  logic        rsp1_ready,
   output logic [31:0] rsp1_y,
   output logic [31:0] fmul_x1,
   output logic [31:0] fmul_x2,
   input  logic [31:0] fmul_y
);

   localparam int unsigned CntW = cnt_width(RSP_DEPTH);
   localparam logic [CntW:0] Budget = (CntW + 1)'(RSP_DEPTH);

   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ-1:0]           rsp_valid;
   logic [NUM_REQ-1:0]           rsp_ready;
   logic [NUM_REQ-1:0]           eligible;
   logic [NUM_REQ-1:0]           cand;
   logic [NUM_REQ-1:0]           push;
   logic [NUM_REQ-1:0]           pop;
   logic [NUM_REQ-1:0][31:0]     req_x1;
   logic [NUM_REQ-1:0][31:0]     req_x2;
   logic [NUM_REQ-1:0][31:0]     rsp_y;
   logic [NUM_REQ-1:0][CntW-1:0] fifo_count;
   logic [NUM_REQ-1:0][CntW-1:0] inflight;
   stage_t [LATENCY-1:0]         stage_q;
   stage_t                       last_stage;
   req_id_t                      last_grant_q;
   req_id_t                      gnt_id;
   logic                         issue;

   assign req_valid  = {req1_valid, req0_valid};
   assign req_x1     = {req1_x1, req0_x1};
   assign req_x2     = {req1_x2, req0_x2};
   assign rsp_ready  = {rsp1_ready, rsp0_ready};
   assign req0_ready = req_ready[0];
   assign req1_ready = req_ready[1];
   assign rsp0_valid = rsp_valid[0];
   assign rsp1_valid = rsp_valid[1];
   assign rsp0_y     = rsp_y[0];
   assign rsp1_y     = rsp_y[1];
   assign last_stage = stage_q[LATENCY-1];
   assign pop        = rsp_valid & rsp_ready;
   assign cand       = req_valid & eligible;

   // Count results still in the fmul pipeline per owner.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < int'(LATENCY); i++) begin
         if (stage_q[i].valid) begin
            inflight[stage_q[i].owner] = inflight[stage_q[i].owner] + CntW'(1);
         end
      end
   end

   // A requester may issue only while its FIFO is guaranteed room for the result;
   // this cycle's pop is deliberately not credited.
   always_comb begin
      eligible = '0;
      for (int n = 0; n < int'(NUM_REQ); n++) begin
         eligible[n] = ({1'b0, fifo_count[n]} + {1'b0, inflight[n]}) < Budget;
      end
   end

   // Round-robin grant among eligible valid requesters; nothing granted during reset.
   always_comb begin
      issue     = 1'b0;
      gnt_id    = '0;
      req_ready = '0;
      if (!rst && (cand != '0)) begin
         issue = 1'b1;
         if (cand == '1) begin
            gnt_id = ~last_grant_q;
         end else if (cand[1]) begin
            gnt_id = req_id_t'(1);
         end
         req_ready[gnt_id] = 1'b1;
      end
   end

   // Operands to the shared fmul follow the grant, zero when idle.
   always_comb begin
      fmul_x1 = '0;
      fmul_x2 = '0;
      if (issue) begin
         fmul_x1 = req_x1[gnt_id];
         fmul_x2 = req_x2[gnt_id];
      end
   end

   // Route the emerging fmul result into its owner's FIFO.
   always_comb begin
      push = '0;
      for (int n = 0; n < int'(NUM_REQ); n++) begin
         push[n] = last_stage.valid && (last_stage.owner == req_id_t'(n));
      end
   end

   // Tracking pipeline mirrors the fmul latency and never stalls; requester 0
   // wins the first tie after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_q      <= '0;
         last_grant_q <= req_id_t'(1);
      end else begin
         stage_q[0] <= '{valid: issue, owner: gnt_id};
         for (int i = 1; i < int'(LATENCY); i++) begin
            stage_q[i] <= stage_q[i-1];
         end
         if (issue) begin
            last_grant_q <= gnt_id;
         end
      end
   end

   for (genvar n = 0; n < NUM_REQ; n++) begin : g_rsp
      fmul_rsp_fifo #(
         .DEPTH (RSP_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .push      (push[n]),
         .push_data (fmul_y),
         .pop       (pop[n]),
         .valid     (rsp_valid[n]),
         .head      (rsp_y[n]),
         .count     (fifo_count[n])
      );
   end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Randomised and directed bench for fmul_arbiter with a 2-cycle fmul model.
module tb_fmul_arbiter;

   localparam int unsigned LATENCY   = 2;
   localparam int unsigned RSP_DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [31:0] rsp0_y, rsp1_y, fmul_x1, fmul_x2, fmul_y;
   logic [31:0] p1, p2;

   // Bench-driven inputs.
   logic [1:0]  d_v  = '0;
   logic [1:0]  d_rr = '0;
   logic [31:0] d_x1 [2];
   logic [31:0] d_x2 [2];

   // Reference model state.
   typedef struct {
      logic [31:0] y;
      int          t;
   } ent_t;
   ent_t mq [2][$];
   int   cyc, lastg;
   int   issued [2];
   int   popped [2];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Per-cycle observations and model decisions for scenario-level checks.
   logic [1:0]  o_rdy, o_rv, m_acc;
   logic [31:0] o_y [2];

   always #5 clk = ~clk;

   // Truncating single-precision multiply for normal operands.
   function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] m;
      logic [22:0] frac;
      int          e;
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      if (m[47]) begin
         e++;
         frac = m[46:24];
      end else begin
         frac = m[45:23];
      end
      return {a[31] ^ b[31], 8'(e), frac};
   endfunction

   function automatic logic [31:0] rand_fp();
      return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
   endfunction

   // Two-stage fmul without reset.
   always @(posedge clk) begin
      p1 <= fp_mul(fmul_x1, fmul_x2);
      p2 <= p1;
   end
   assign fmul_y = p2;

   fmul_arbiter #(
      .LATENCY   (LATENCY),
      .RSP_DEPTH (RSP_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (d_v[0]),
      .req0_ready (req0_ready),
      .req0_x1    (d_x1[0]),
      .req0_x2    (d_x2[0]),
      .req1_valid (d_v[1]),
      .req1_ready (req1_ready),
      .req1_x1    (d_x1[1]),
      .req1_x2    (d_x2[1]),
      .rsp0_valid (rsp0_valid),
      .rsp0_ready (d_rr[0]),
      .rsp0_y     (rsp0_y),
      .rsp1_valid (rsp1_valid),
      .rsp1_ready (d_rr[1]),
      .rsp1_y     (rsp1_y),
      .fmul_x1    (fmul_x1),
      .fmul_x2    (fmul_x2),
      .fmul_y     (fmul_y)
   );

   // One clock cycle: predict from transaction-level rules, compare, advance model.
   // Entered and left just after a falling edge.
   task automatic run_cycle();
      logic [1:0]  cand, exp_rdy, exp_rv;
      logic [31:0] exp_x1, exp_x2;
      int          g;
      #1;
      for (int n = 0; n < 2; n++) begin
         cand[n]   = d_v[n] && !rst && ((issued[n] - popped[n]) < int'(RSP_DEPTH));
         exp_rv[n] = (mq[n].size() > 0) && (mq[n][0].t <= cyc);
      end
      g = -1;
      if (cand == 2'b11) g = 1 - lastg;
      else if (cand[0]) g = 0;
      else if (cand[1]) g = 1;
      exp_rdy = '0;
      exp_x1  = '0;
      exp_x2  = '0;
      if (g >= 0) begin
         exp_rdy[g] = 1'b1;
         exp_x1     = d_x1[g];
         exp_x2     = d_x2[g];
      end
      o_rdy   = {req1_ready, req0_ready};
      o_rv    = {rsp1_valid, rsp0_valid};
      o_y[0]  = rsp0_y;
      o_y[1]  = rsp1_y;

      n_checks++;
      if (o_rdy !== exp_rdy) $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, o_rdy, exp_rdy);
      else n_pass++;
      n_checks++;
      if (o_rv !== exp_rv) $display("FAIL rsp_valid cyc=%0d got=%b exp=%b", cyc, o_rv, exp_rv);
      else n_pass++;
      for (int n = 0; n < 2; n++) begin
         if (exp_rv[n]) begin
            n_checks++;
            if (o_y[n] !== mq[n][0].y)
               $display("FAIL rsp%0d_y cyc=%0d got=%h exp=%h", n, cyc, o_y[n], mq[n][0].y);
            else n_pass++;
         end
      end
      n_checks++;
      if (fmul_x1 !== exp_x1 || fmul_x2 !== exp_x2)
         $display("FAIL fmul_x cyc=%0d got=%h/%h exp=%h/%h", cyc, fmul_x1, fmul_x2, exp_x1,
                  exp_x2);
      else n_pass++;

      m_acc = exp_rdy;
      if (g >= 0) begin
         mq[g].push_back('{y: fp_mul(d_x1[g], d_x2[g]), t: cyc + int'(LATENCY) + 1});
         issued[g]++;
         lastg = g;
      end
      for (int n = 0; n < 2; n++) begin
         if (exp_rv[n] && d_rr[n]) begin
            void'(mq[n].pop_front());
            popped[n]++;
         end
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         mq[n].delete();
         issued[n] = 0;
         popped[n] = 0;
      end
      lastg = 1;
      run_cycle();
      run_cycle();
      rst  = 1'b0;
      d_v  = '0;
      cyc  = 0;
   endtask

   task automatic test_reset();
      d_v     = 2'b11;
      d_rr    = 2'b11;
      d_x1[0] = rand_fp();
      d_x2[0] = rand_fp();
      d_x1[1] = rand_fp();
      d_x2[1] = rand_fp();
      apply_reset();
      n_checks++;
      if (o_rdy !== 2'b00) $display("FAIL reset_ready got=%b exp=00", o_rdy);
      else n_pass++;
      n_checks++;
      if (o_rv !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", o_rv);
      else n_pass++;
   endtask

   task automatic test_single();
      int first = -1, t;
      logic saw1 = 1'b0;
      logic [31:0] y = '0;
      apply_reset();
      d_rr    = 2'b11;
      d_v     = 2'b01;
      d_x1[0] = 32'h4000_0000;
      d_x2[0] = 32'h4040_0000;
      t       = cyc;
      for (int k = 0; k < 8; k++) begin
         int c = cyc;
         run_cycle();
         if (m_acc[0]) d_v[0] = 1'b0;
         if (o_rv[0] && first < 0) begin
            first = c;
            y     = o_y[0];
         end
         if (o_rv[1]) saw1 = 1'b1;
      end
      n_checks++;
      if (first != t + 3) $display("FAIL single_latency got=%0d exp=%0d", first, t + 3);
      else n_pass++;
      n_checks++;
      if (y !== 32'h40C0_0000) $display("FAIL single_y got=%h exp=40c00000", y);
      else n_pass++;
      n_checks++;
      if (saw1 !== 1'b0) $display("FAIL single_rsp1 got=%b exp=0", saw1);
      else n_pass++;
   endtask

   task automatic test_tie();
      int f0 = -1, f1 = -1, t;
      logic [31:0] y0 = '0, y1 = '0;
      apply_reset();
      d_rr    = 2'b11;
      d_v     = 2'b11;
      d_x1[0] = 32'h3FC0_0000;
      d_x2[0] = 32'h3FC0_0000;
      d_x1[1] = 32'hBF80_0000;
      d_x2[1] = 32'h4080_0000;
      t       = cyc;
      for (int k = 0; k < 8; k++) begin
         int c = cyc;
         run_cycle();
         if (c == t) begin
            n_checks++;
            if (o_rdy !== 2'b01) $display("FAIL tie_first_grant got=%b exp=01", o_rdy);
            else n_pass++;
         end
         d_v = d_v & ~m_acc;
         if (o_rv[0] && f0 < 0) begin f0 = c; y0 = o_y[0]; end
         if (o_rv[1] && f1 < 0) begin f1 = c; y1 = o_y[1]; end
      end
      n_checks++;
      if (f0 != t + 3 || y0 !== 32'h4010_0000)
         $display("FAIL tie_rsp0 got=%0d/%h exp=%0d/40100000", f0, y0, t + 3);
      else n_pass++;
      n_checks++;
      if (f1 != t + 4 || y1 !== 32'hC080_0000)
         $display("FAIL tie_rsp1 got=%0d/%h exp=%0d/c0800000", f1, y1, t + 4);
      else n_pass++;
   endtask

   task automatic test_alternate();
      int pops [2] = '{0, 0};
      apply_reset();
      d_rr = 2'b11;
      for (int k = 0; k < 14; k++) begin
         d_v = (k < 8) ? 2'b11 : 2'b00;
         for (int n = 0; n < 2; n++) begin
            d_x1[n] = rand_fp();
            d_x2[n] = rand_fp();
         end
         run_cycle();
         if (k < 8) begin
            n_checks++;
            if (o_rdy !== ((k % 2 == 0) ? 2'b01 : 2'b10))
               $display("FAIL alt_grant k=%0d got=%b", k, o_rdy);
            else n_pass++;
         end
         for (int n = 0; n < 2; n++) if (o_rv[n] && d_rr[n]) pops[n]++;
      end
      n_checks++;
      if (pops[0] != 4 || pops[1] != 4)
         $display("FAIL alt_results got=%0d/%0d exp=4/4", pops[0], pops[1]);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int acc0 = 0, pops0 = 0;
      apply_reset();
      d_rr = 2'b10;
      d_v  = 2'b11;
      for (int n = 0; n < 2; n++) begin
         d_x1[n] = rand_fp();
         d_x2[n] = rand_fp();
      end
      for (int k = 0; k < 14; k++) begin
         run_cycle();
         if (o_rdy[0]) acc0++;
         if (k >= 8) begin
            n_checks++;
            if (o_rdy !== 2'b10) $display("FAIL bp_stall k=%0d got=%b exp=10", k, o_rdy);
            else n_pass++;
         end
         for (int n = 0; n < 2; n++) begin
            if (m_acc[n]) begin
               d_x1[n] = rand_fp();
               d_x2[n] = rand_fp();
            end
         end
      end
      n_checks++;
      if (acc0 != int'(RSP_DEPTH)) $display("FAIL bp_accepts got=%0d exp=%0d", acc0, RSP_DEPTH);
      else n_pass++;
      d_v  = 2'b00;
      d_rr = 2'b11;
      for (int k = 0; k < 8; k++) begin
         run_cycle();
         if (o_rv[0]) pops0++;
      end
      n_checks++;
      if (pops0 != int'(RSP_DEPTH)) $display("FAIL bp_drain got=%0d exp=%0d", pops0, RSP_DEPTH);
      else n_pass++;
   endtask

   task automatic test_throughput();
      int acc = 0;
      apply_reset();
      d_rr = 2'b11;
      for (int k = 0; k < 15; k++) begin
         d_v     = (k < 10) ? 2'b10 : 2'b00;
         d_x1[1] = rand_fp();
         d_x2[1] = rand_fp();
         run_cycle();
         if (o_rdy[1]) acc++;
      end
      n_checks++;
      if (acc != 10) $display("FAIL throughput got=%0d exp=10", acc);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      logic saw = 1'b0;
      int   f = -1, t;
      logic [31:0] y = '0;
      apply_reset();
      d_rr = 2'b11;
      d_v  = 2'b11;
      for (int n = 0; n < 2; n++) begin
         d_x1[n] = rand_fp();
         d_x2[n] = rand_fp();
      end
      run_cycle();
      d_v = d_v & ~m_acc;
      run_cycle();
      d_v = 2'b00;
      apply_reset();
      for (int k = 0; k < 8; k++) begin
         run_cycle();
         if (o_rv != 2'b00) saw = 1'b1;
      end
      n_checks++;
      if (saw !== 1'b0) $display("FAIL midrst_stale got=%b exp=0", saw);
      else n_pass++;
      d_v     = 2'b10;
      d_x1[1] = 32'h3FC0_0000;
      d_x2[1] = 32'h3FC0_0000;
      t       = cyc;
      for (int k = 0; k < 6; k++) begin
         int c = cyc;
         run_cycle();
         d_v = d_v & ~m_acc;
         if (o_rv[1] && f < 0) begin f = c; y = o_y[1]; end
      end
      n_checks++;
      if (f != t + 3 || y !== 32'h4010_0000)
         $display("FAIL midrst_post got=%0d/%h exp=%0d/40100000", f, y, t + 3);
      else n_pass++;
   endtask

   task automatic test_random();
      int pops [2] = '{0, 0};
      apply_reset();
      for (int k = 0; k < 400; k++) begin
         for (int n = 0; n < 2; n++) begin
            if (!d_v[n] || m_acc[n] || k == 0) begin
               d_v[n]  = ($urandom_range(9, 0) < 7);
               d_x1[n] = rand_fp();
               d_x2[n] = rand_fp();
            end
            d_rr[n] = ($urandom_range(9, 0) < 6);
         end
         run_cycle();
         for (int n = 0; n < 2; n++) if (o_rv[n] && d_rr[n]) pops[n]++;
      end
      d_v  = 2'b00;
      d_rr = 2'b11;
      for (int k = 0; k < 12; k++) begin
         run_cycle();
         for (int n = 0; n < 2; n++) if (o_rv[n] && d_rr[n]) pops[n]++;
      end
      for (int n = 0; n < 2; n++) begin
         n_checks++;
         if (pops[n] != issued[n])
            $display("FAIL random_drain%0d got=%0d exp=%0d", n, pops[n], issued[n]);
         else n_pass++;
      end
   endtask

   initial begin
      rst     = 1'b1;
      d_x1[0] = '0;
      d_x2[0] = '0;
      d_x1[1] = '0;
      d_x2[1] = '0;
      m_acc   = '0;
      @(negedge clk);
      test_reset();
      test_single();
      test_tie();
      test_alternate();
      test_backpressure();
      test_throughput();
      test_mid_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
